fetch_stage: RTL

//  F stage of the 5-stage MIPS pipeline, and the producer side of the D-stage interface.

---
 rtl/fetch_stage_if.sv | 36 +++
 rtl/fetch_stage.sv | 114 +++++++++++
 2 files changed

// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: D-stage feedback, instruction-memory port and IF/ID outputs.
// FETCH_EXC_EN adds the fetch_fault flag.
interface fetch_stage_if #(
  parameter int IM_AW = 10
);
  logic             stall_F;
  logic [31:0]      npc;
  logic [1:0]       PCsrc;
  logic [IM_AW-1:0] im_addr;
  logic [31:0]      im_rdata;
  logic [31:0]      PC_F;
  logic [31:0]      PC_D;
  logic [31:0]      instr;
  logic [31:0]      fetch_cnt;
`ifdef FETCH_EXC_EN
  logic             fetch_fault;

  modport master (
    input  stall_F, npc, PCsrc, im_rdata,
    output im_addr, PC_F, PC_D, instr, fetch_cnt, fetch_fault
  );
  modport slave (
    output stall_F, npc, PCsrc, im_rdata,
    input  im_addr, PC_F, PC_D, instr, fetch_cnt, fetch_fault
  );
`else
  modport master (
    input  stall_F, npc, PCsrc, im_rdata,
    output im_addr, PC_F, PC_D, instr, fetch_cnt
  );
  modport slave (
    output stall_F, npc, PCsrc, im_rdata,
    input  im_addr, PC_F, PC_D, instr, fetch_cnt
  );
`endif
endinterface

// File: rtl/fetch_stage.sv
// MIPS F stage: PC register, IM addressing and IF/ID register, one delay slot.
// FETCH_EXC_EN enables the fetch-fault checker (states RUN / FAULT).
module fetch_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter int          IM_AW    = 10
) (
  input  logic          clk,
  input  logic          reset,
  fetch_stage_if.master bus
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] pcd_q, pcd_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] pc_off;
  logic [31:0] next_pc;

  assign pc_off  = pc_q - PC_RESET;
  assign next_pc = (bus.PCsrc == 2'd1 || bus.PCsrc == 2'd2) ? bus.npc : pc_q + 32'd4;

  assign bus.im_addr   = pc_off[IM_AW+1:2];
  assign bus.PC_F      = pc_q;
  assign bus.PC_D      = pcd_q;
  assign bus.instr     = instr_q;
  assign bus.fetch_cnt = cnt_q;

`ifdef FETCH_EXC_EN
  // state | meaning
  // RUN   | normal fetch, PC checked every cycle
  // FAULT | bad PC seen; PC frozen, nops fed to D until reset
  typedef enum logic {RUN, FAULT} state_t;

  state_t state_q, state_d;
  logic   fault_q, fault_d;
  logic   fetch_bad;

  assign fetch_bad = (pc_q[1:0] != 2'b00) || (pc_q < PC_RESET) ||
                     ((pc_off >> (IM_AW + 2)) != 32'd0);
  assign bus.fetch_fault = fault_q;

  always_comb begin
    pc_d    = pc_q;
    pcd_d   = pcd_q;
    instr_d = instr_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    fault_d = fault_q;
    case (state_q)
      RUN: begin
        if (!bus.stall_F) begin
          if (fetch_bad) begin
            pcd_d   = pc_q;
            instr_d = '0;
            fault_d = 1'b1;
            state_d = FAULT;
          end else begin
            pc_d    = next_pc;
            pcd_d   = pc_q;
            instr_d = bus.im_rdata;
            cnt_d   = cnt_q + 32'd1;
          end
        end
      end
      FAULT: begin
        instr_d = '0;
        fault_d = 1'b1;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fault_q <= fault_d;
    end
  end
`else
  logic unused_pc_off;
  assign unused_pc_off = ^{pc_off[31:IM_AW+2], pc_off[1:0]};

  always_comb begin
    pc_d    = pc_q;
    pcd_d   = pcd_q;
    instr_d = instr_q;
    cnt_d   = cnt_q;
    if (!bus.stall_F) begin
      pc_d    = next_pc;
      pcd_d   = pc_q;
      instr_d = bus.im_rdata;
      cnt_d   = cnt_q + 32'd1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= PC_RESET;
      pcd_q   <= PC_RESET;
      instr_q <= '0;
      cnt_q   <= '0;
    end else begin
      pc_q    <= pc_d;
      pcd_q   <= pcd_d;
      instr_q <= instr_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
